cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Schedules the single common data bus (CDB) shared by the ALU and the LSB result producers.
- Buffers each producer's results in a small per-source FIFO.
- Grants one result per cycle round-robin and drives the registered CDB that the ROB, RS and LSB snoop.
- Applies backpressure when a FIFO fills and discards all in-flight results on a mispredict flush.

Parameters:
ROB_W, 4, width of ROB reorder tag.
DATA_W, 32, result value width.
DEPTH, 4, entries per source FIFO; power of two, at least 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-low (0 = reset).
rdy  in  1  global ready; when low, block is frozen.
flush  in  1  mispredict clear (ROB jp_wrong).
alu_flag  in  1  ALU result valid.
alu_reorder  in  ROB_W  ALU result tag.
alu_val  in  DATA_W  ALU result value.
alu_full  out  1  ALU FIFO full; ALU must not assert alu_flag.
lsb_flag  in  1  LSB result valid.
lsb_reorder  in  ROB_W  LSB result tag.
lsb_val  in  DATA_W  LSB result value.
lsb_full  out  1  LSB FIFO full.
cdb_flag  out  1  CDB broadcast valid.
cdb_reorder  out  ROB_W  broadcast tag.
cdb_val  out  DATA_W  broadcast value.
cdb_src  out  1  granted source, 0 = ALU, 1 = LSB (debug).
ovf_err  out  1  sticky: a push was attempted while full.

Behaviour:
Reset (rst = 0, async):
- Both FIFOs empty; cdb_flag = 0, cdb_reorder = 0, cdb_val = 0, cdb_src = 0.
- alu_full = lsb_full = 0; ovf_err = 0.
- last_grant = LSB, so the ALU wins the first tie.
- Reset release is sampled on the next clk edge.

Freeze:
- When rdy = 0: no state changes, all outputs hold, flag inputs ignored.

Flush:
- rdy = 1 and flush = 1 at an edge: both FIFOs are emptied.
- That cycle's flag inputs are dropped.
- cdb_flag = 0 from the next cycle.
- last_grant and ovf_err are unchanged.
- flush has priority over every other event.

Candidate per source each edge:
- FIFO head if the FIFO is non-empty.
- Otherwise the incoming result if its flag = 1 (bypass).
- Otherwise none.

Grant:
- Only one candidate exists: it wins.
- Both exist: the source != last_grant wins, and last_grant updates to the winner.
- No candidate: cdb_flag = 0 next cycle, reorder/val hold their old values, last_grant unchanged.

Output register:
- The winner's tag and value are loaded at the edge; cdb_flag = 1 for exactly that following cycle.
- Latency is 1 edge for a bypassed result (input at edge k, on CDB after edge k). A buffered result appears on the edge on which it wins.

Push:
- An incoming valid result not consumed by bypass is written to its FIFO tail.
- A source's FIFO is never bypassed while non-empty; per-source order is preserved.
- An incoming valid result is never lost unless full or flushed.

Full:
- alu_full / lsb_full = (count == DEPTH), taken from registered count.
- A push while full is refused even if a pop occurs the same edge; the result is dropped and ovf_err is set.
- Simultaneous pop and push on a non-full FIFO: count unchanged.

Pointers:
- log2(DEPTH) bits, wrap modulo DEPTH.
- Count is log2(DEPTH)+1 bits.

Starvation bound:
- With both sources continuously pending, each is granted at least every 2nd cycle.

Test Plan:
- Reset: hold rst = 0, then release → cdb_flag = 0, alu_full = lsb_full = 0, ovf_err = 0. Assert rst low mid-traffic → outputs 0 asynchronously, before the next edge.
- Bypass: idle, then alu_flag = 1, tag 3, val 0x0000_00AA for one edge → next cycle cdb_flag = 1, cdb_reorder = 3, cdb_val = 0xAA, cdb_src = 0; following cycle cdb_flag = 0.
- Tie/round-robin: ALU (tag 1, 0x11) and LSB (tag 2, 0x22) the same edge after reset → ALU broadcast first, LSB next cycle. Then hold both flags for 4 edges with tags 4..7 → strict alternation with no lost results; total broadcast order matches per-source order.
- Full/backpressure: DEPTH = 4, LSB flag held continuously and ALU flag held continuously → LSB FIFO fills and lsb_full = 1 after its 4th buffered entry. An extra forced LSB push → ovf_err = 1, that result is never broadcast.
- Flush: 3 ALU results buffered; flush = 1 with lsb_flag = 1 the same edge → next cycle cdb_flag = 0, both FIFOs empty, alu_full = 0. The LSB result from that edge never appears.
- Freeze: rdy = 0 for 5 cycles with buffered entries and a flag input asserted → all outputs constant; after rdy = 1, broadcasts resume with the original head entry.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// ============================================================================
// cdb_arbiter_if : producer result ports and CDB broadcast bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface cdb_arbiter_if #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
);
    logic              alu_flag;
    logic [ROB_W-1:0]  alu_reorder;
    logic [DATA_W-1:0] alu_val;
    logic              alu_full;
    logic              lsb_flag;
    logic [ROB_W-1:0]  lsb_reorder;
    logic [DATA_W-1:0] lsb_val;
    logic              lsb_full;
    logic              cdb_flag;
    logic [ROB_W-1:0]  cdb_reorder;
    logic [DATA_W-1:0] cdb_val;
    logic              cdb_src;
    logic              ovf_err;

    modport master (
        output alu_flag, alu_reorder, alu_val,
        output lsb_flag, lsb_reorder, lsb_val,
        input  alu_full, lsb_full,
        input  cdb_flag, cdb_reorder, cdb_val, cdb_src, ovf_err
    );

    modport slave (
        input  alu_flag, alu_reorder, alu_val,
        input  lsb_flag, lsb_reorder, lsb_val,
        output alu_full, lsb_full,
        output cdb_flag, cdb_reorder, cdb_val, cdb_src, ovf_err
    );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : per-source result FIFOs with round-robin grant onto the CDB
// Revision 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   rdy,
    input  wire logic   flush,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ROB_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q  [2][DEPTH];
    logic [ENT_W-1:0] mem_d  [2][DEPTH];
    logic [PTR_W-1:0] wptr_q [2];
    logic [PTR_W-1:0] wptr_d [2];
    logic [PTR_W-1:0] rptr_q [2];
    logic [PTR_W-1:0] rptr_d [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];

    logic              last_q, last_d;
    logic              cdb_flag_q, cdb_flag_d;
    logic              cdb_src_q, cdb_src_d;
    logic              ovf_q, ovf_d;
    logic [ROB_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_val_q, cdb_val_d;

    logic             in_flag [2];
    logic [ENT_W-1:0] in_data [2];
    logic             empty   [2];
    logic             full    [2];
    logic             cand    [2];
    logic [ENT_W-1:0] head    [2];
    logic             grant   [2];
    logic             pop     [2];
    logic             push_ok [2];
    logic             any_cand;
    logic             win;

    always_comb begin
        in_flag[0] = bus.alu_flag;
        in_data[0] = {bus.alu_reorder, bus.alu_val};
        in_flag[1] = bus.lsb_flag;
        in_data[1] = {bus.lsb_reorder, bus.lsb_val};
    end

    // Candidate is the FIFO head when buffered, else the bypassed input.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            empty[s] = (cnt_q[s] == '0);
            full[s]  = (cnt_q[s] == FULL_CNT);
            cand[s]  = !empty[s] || in_flag[s];
            head[s]  = empty[s] ? in_data[s] : mem_q[s][rptr_q[s]];
        end
        any_cand = cand[0] || cand[1];
        win      = (cand[0] && cand[1]) ? ~last_q : cand[1];
        grant[0] = any_cand && !win;
        grant[1] = any_cand && win;
    end

    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        cdb_flag_d = cdb_flag_q;
        cdb_src_d  = cdb_src_q;
        cdb_tag_d  = cdb_tag_q;
        cdb_val_d  = cdb_val_q;
        ovf_d      = ovf_q;
        for (int s = 0; s < 2; s++) begin
            pop[s]     = 1'b0;
            push_ok[s] = 1'b0;
        end

        if (rdy) begin
            if (flush) begin
                for (int s = 0; s < 2; s++) begin
                    wptr_d[s] = '0;
                    rptr_d[s] = '0;
                    cnt_d[s]  = '0;
                end
                cdb_flag_d = 1'b0;
            end else begin
                cdb_flag_d = any_cand;
                if (any_cand) begin
                    {cdb_tag_d, cdb_val_d} = head[win];
                    cdb_src_d = win;
                    last_d    = win;
                end
                // Fullness is judged before this edge's pop, so a full FIFO refuses pushes.
                for (int s = 0; s < 2; s++) begin
                    pop[s]     = grant[s] && !empty[s];
                    push_ok[s] = in_flag[s] && !(grant[s] && empty[s]) && !full[s];
                    if (in_flag[s] && full[s])
                        ovf_d = 1'b1;
                    if (push_ok[s]) begin
                        mem_d[s][wptr_q[s]] = in_data[s];
                        wptr_d[s] = wptr_q[s] + PTR_W'(1);
                    end
                    if (pop[s])
                        rptr_d[s] = rptr_q[s] + PTR_W'(1);
                    cnt_d[s] = cnt_q[s] + {{(CNT_W-1){1'b0}}, push_ok[s]}
                                        - {{(CNT_W-1){1'b0}}, pop[s]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int e = 0; e < DEPTH; e++)
                    mem_q[s][e] <= '0;
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            last_q     <= 1'b1;
            cdb_flag_q <= 1'b0;
            cdb_src_q  <= 1'b0;
            cdb_tag_q  <= '0;
            cdb_val_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            cdb_flag_q <= cdb_flag_d;
            cdb_src_q  <= cdb_src_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_val_q  <= cdb_val_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.alu_full    = full[0];
    assign bus.lsb_full    = full[1];
    assign bus.cdb_flag    = cdb_flag_q;
    assign bus.cdb_reorder = cdb_tag_q;
    assign bus.cdb_val     = cdb_val_q;
    assign bus.cdb_src     = cdb_src_q;
    assign bus.ovf_err     = ovf_q;

endmodule

`default_nettype wire
